// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps the datapath through
// fetch / decode / execute / memory / writeback, drives the memory handshakes,
// register and memory write enables and the PC update strobes, counts retired
// instructions and traps to FAULT when a memory port stops responding.
//
// Opcode map (4-bit):
//   0 ADD  1 SUB  2 SFT  3 INC  4 LHB  5 LIM  6 MVB  7 MVF
//   8 LB   9 STR 10 BNE 11 BEQ 12 BLT 13 JMP 14 TBA 15 HALT
module multicycle_sequencer #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             imm_flag,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_FAULT  = 3'd7;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_MVF  = 4'd7;
  localparam logic [3:0] OP_LB   = 4'd8;
  localparam logic [3:0] OP_STR  = 4'd9;
  localparam logic [3:0] OP_BNE  = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_BLT  = 4'd12;
  localparam logic [3:0] OP_JMP  = 4'd13;
  localparam logic [3:0] OP_TBA  = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  // Stall counter only has to reach MEM_TIMEOUT-1.
  localparam int              WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [2:0]        state_next;
  logic [3:0]        op_q;
  logic              imm_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              retire;
  logic              stalling;
  logic              is_alu;
  logic              is_mem;
  logic              is_branch;

  // The variant bit travels with the opcode for the datapath decoder; no
  // sequencing decision depends on it.
  logic ir_variant_unused;
  assign ir_variant_unused = imm_q;

  assign is_alu    = (op_q >= OP_ADD) && (op_q <= OP_MVF);
  assign is_mem    = (op_q == OP_LB) || (op_q == OP_STR);
  assign is_branch = (op_q == OP_BNE) || (op_q == OP_BEQ) || (op_q == OP_BLT);
  assign stalling  = ((state == S_FETCH) && !imem_ready) ||
                     ((state == S_MEM)   && !dmem_ready);

  // Next-state and retire decision.
  always_comb begin
    // NOTE: every signal gets a default up front so no path can infer a latch.
    state_next = state;
    retire     = 1'b0;
    case (state)
      S_IDLE:   if (run) state_next = S_FETCH;
      // A ready response wins over the timeout on the last allowed cycle.
      S_FETCH: begin
        if (imem_ready)                state_next = S_DECODE;
        else if (wait_cnt == WAIT_LAST) state_next = S_FAULT;
      end
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          state_next = S_HALT;
          retire     = 1'b1;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_alu)      state_next = S_WB;
        else if (is_mem) state_next = S_MEM;
        else begin
          // Branches, JMP and TBA finish here.
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (op_q == OP_STR) begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end else begin
            state_next = S_WB;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = S_FAULT;
        end
      end
      S_WB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      default: state_next = state;  // HALT and FAULT hold until reset
    endcase
  end

  // State, latched instruction fields, stall counter and retired counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= 4'd0;
      imm_q    <= 1'b0;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        op_q  <= opcode;
        imm_q <= imm_flag;
      end
      // Any state change restarts the stall count for the next wait.
      if (state_next != state) wait_cnt <= '0;
      else if (stalling)       wait_cnt <= wait_cnt + WAIT_W'(1);
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // Control strobes decoded from the current state (plus same-cycle handshakes).
  assign imem_req = (state == S_FETCH);
  assign ir_load  = imem_req && imem_ready;
  assign dmem_req = (state == S_MEM);
  assign dmem_we  = dmem_req && (op_q == OP_STR);
  assign reg_we   = (state == S_WB);
  assign pc_load  = (state == S_EXEC) &&
                    ((is_branch && branch_taken) || (op_q == OP_JMP));
  assign pc_inc   = ((state == S_EXEC) &&
                     ((is_branch && !branch_taken) || (op_q == OP_TBA))) ||
                    (dmem_we && dmem_ready) ||
                    reg_we;
  assign halted   = (state == S_HALT);
  assign fault    = (state == S_FAULT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer. The reference model treats each instruction
// as a queue of phases (fetch, decode, then an opcode-dependent tail); an
// instruction retires when its queue empties. Memory phases stall while the
// port is not ready and trap after MEM_TIMEOUT stalled cycles.
module tb_multicycle_sequencer;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 8;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd8;
  localparam logic [3:0] OP_STR  = 4'd9;
  localparam logic [3:0] OP_BNE  = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_BLT  = 4'd12;
  localparam logic [3:0] OP_JMP  = 4'd13;
  localparam logic [3:0] OP_TBA  = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam byte P_F = 1, P_D = 2, P_E = 3, P_M = 4, P_W = 5;

  logic clk = 1'b0;
  logic reset, run, imm_flag, branch_taken, imem_ready, dmem_ready;
  logic [3:0] opcode;
  logic imem_req, ir_load, dmem_req, dmem_we, reg_we, pc_inc, pc_load, halted, fault;
  logic [2:0] state;
  logic [CNT_W-1:0] retired;

  multicycle_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .imm_flag(imm_flag),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_we(reg_we), .pc_inc(pc_inc), .pc_load(pc_load), .halted(halted),
    .fault(fault), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int        m_mode = 0;      // 0 idle, 1 running, 2 halted, 3 faulted
  byte       m_q[$];          // remaining phases of the current instruction
  int        m_wait = 0;      // stalled cycles in the current memory phase
  int        m_retired = 0;
  logic [3:0] m_op = 4'd0;

  function automatic bit is_br(input logic [3:0] op);
    return (op == OP_BNE) || (op == OP_BEQ) || (op == OP_BLT);
  endfunction

  // Expected outputs {imem_req, ir_load, dmem_req, dmem_we, reg_we, pc_inc,
  // pc_load, halted, fault, state[2:0], retired[3:0]} for the current cycle.
  function automatic logic [15:0] model_out();
    logic ir = 0, il = 0, dr = 0, dw = 0, rw = 0, pi = 0, pl = 0, h = 0, f = 0;
    logic [2:0] st = 3'd0;
    if (m_mode == 2) begin h = 1; st = 3'd6; end
    else if (m_mode == 3) begin f = 1; st = 3'd7; end
    else if (m_mode == 1) begin
      case (m_q[0])
        P_F: begin st = 3'd1; ir = 1; il = imem_ready; end
        P_D: st = 3'd2;
        P_E: begin
          st = 3'd3;
          if (is_br(m_op)) begin pl = branch_taken; pi = !branch_taken; end
          else if (m_op == OP_JMP) pl = 1;
          else if (m_op == OP_TBA) pi = 1;
        end
        P_M: begin
          st = 3'd4; dr = 1; dw = (m_op == OP_STR);
          pi = (m_op == OP_STR) && dmem_ready;
        end
        default: begin st = 3'd5; rw = 1; pi = 1; end
      endcase
    end
    return {ir, il, dr, dw, rw, pi, pl, h, f, st, 4'(m_retired)};
  endfunction

  // Advance the model across one clock edge using the inputs held this cycle.
  function automatic void model_step();
    byte cur;
    bit  done;
    if (reset) begin
      m_mode = 0; m_q.delete(); m_wait = 0; m_retired = 0;
      return;
    end
    if (m_mode == 0) begin
      if (run) begin m_mode = 1; m_q = {P_F, P_D}; m_wait = 0; end
    end else if (m_mode == 1) begin
      cur  = m_q[0];
      done = (cur == P_F) ? imem_ready : (cur == P_M) ? dmem_ready : 1'b1;
      if (!done) begin
        if (m_wait + 1 >= MEM_TIMEOUT) m_mode = 3;
        else m_wait++;
      end else begin
        if (cur == P_D) begin
          m_op = opcode;
          if (opcode <= 4'd7) begin m_q.push_back(P_E); m_q.push_back(P_W); end
          else if (opcode == OP_LB) begin
            m_q.push_back(P_E); m_q.push_back(P_M); m_q.push_back(P_W);
          end else if (opcode == OP_STR) begin m_q.push_back(P_E); m_q.push_back(P_M); end
          else if (opcode != OP_HALT) m_q.push_back(P_E);
        end
        void'(m_q.pop_front());
        m_wait = 0;
        if (m_q.size() == 0) begin
          m_retired = (m_retired + 1) % (1 << CNT_W);
          if (m_op == OP_HALT) m_mode = 2;
          else m_q = {P_F, P_D};
        end
      end
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  logic [15:0] dut_vec;
  assign dut_vec = {imem_req, ir_load, dmem_req, dmem_we, reg_we, pc_inc, pc_load,
                    halted, fault, state, retired};

  int tr_state[$];
  int tr_ctl[$];   // {reg_we, pc_inc, pc_load}
  int tr_mem[$];   // {dmem_req, dmem_we}

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    #1;
    check("cycle outputs", 32'(dut_vec), 32'(model_out()));
    tr_state.push_back(int'(state));
    tr_ctl.push_back(int'({reg_we, pc_inc, pc_load}));
    tr_mem.push_back(int'({dmem_req, dmem_we}));
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_trace();
    tr_state.delete(); tr_ctl.delete(); tr_mem.delete();
  endtask

  task automatic drive(input logic rn, input logic [3:0] op, input logic bt,
                       input logic ir, input logic dr);
    run = rn; opcode = op; branch_taken = bt; imem_ready = ir; dmem_ready = dr;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int burst = 0;
  int n_fetch;

  initial begin
    reset = 1'b1; imm_flag = 1'b0;
    drive(0, OP_ADD, 0, 0, 0);
    @(posedge clk); model_step(); @(negedge clk);
    reset = 1'b0;
    #1 check("reset state", 32'(dut_vec), 32'h0);

    // ADD with zero wait: IDLE, FETCH, DECODE, EXEC, WB, FETCH
    drive(1, OP_ADD, 0, 1, 1);
    clear_trace();
    repeat (6) tick();
    begin
      int exp_st[6]  = '{0, 1, 2, 3, 5, 1};
      int exp_ctl[6] = '{0, 0, 0, 0, 6, 0};
      for (int i = 0; i < 6; i++) begin
        check($sformatf("add state[%0d]", i), 32'(tr_state[i]), 32'(exp_st[i]));
        check($sformatf("add ctl[%0d]", i), 32'(tr_ctl[i]), 32'(exp_ctl[i]));
      end
    end
    check("add retired", 32'(retired), 32'd1);

    // BEQ taken then not taken
    do_reset();
    drive(1, OP_BEQ, 1, 1, 1);
    clear_trace();
    repeat (4) tick();                     // IDLE, FETCH, DECODE, EXEC
    check("beq taken state", 32'(tr_state[3]), 32'd3);
    check("beq taken ctl", 32'(tr_ctl[3]), 32'd1);
    branch_taken = 1'b0;
    clear_trace();
    repeat (3) tick();                     // FETCH, DECODE, EXEC
    check("beq not-taken ctl", 32'(tr_ctl[2]), 32'd2);
    check("branch retired", 32'(retired), 32'd2);

    // STR with ready on the fourth MEM cycle
    do_reset();
    drive(1, OP_STR, 0, 1, 0);
    repeat (4) tick();                     // IDLE, FETCH, DECODE, EXEC
    clear_trace();
    repeat (3) tick();
    dmem_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++)
      check($sformatf("str mem[%0d]", i), 32'(tr_mem[i]), 32'd3);
    check("str pc_inc", 32'(tr_ctl[3]), 32'd2);
    dmem_ready = 1'b0;
    tick();
    check("str back to fetch", 32'(tr_state[4]), 32'd1);
    check("str retired", 32'(retired), 32'd1);

    // Instruction memory never answers: FAULT after MEM_TIMEOUT fetch cycles
    do_reset();
    drive(1, OP_ADD, 0, 0, 0);
    tick();
    clear_trace();
    repeat (MEM_TIMEOUT + 4) tick();
    n_fetch = 0;
    foreach (tr_state[i]) if (tr_state[i] == 1) n_fetch++;
    check("fetch cycles before fault", 32'(n_fetch), 32'(MEM_TIMEOUT));
    check("fault state", 32'(tr_state[MEM_TIMEOUT]), 32'd7);
    check("fault sticky", 32'(fault), 32'd1);
    check("no request in fault", 32'(imem_req), 32'd0);
    do_reset();
    check("reset from fault", 32'(state), 32'd0);

    // Response on the last allowed fetch cycle is accepted
    drive(1, OP_ADD, 0, 0, 0);
    tick();
    repeat (MEM_TIMEOUT - 1) tick();
    imem_ready = 1'b1;
    tick();
    check("late response accepted", 32'(state), 32'd2);

    // HALT: sticky, run ignored, retired counted
    do_reset();
    drive(1, OP_HALT, 0, 1, 1);
    repeat (3) tick();                     // IDLE, FETCH, DECODE
    for (int i = 0; i < 6; i++) begin
      run = (i % 2 == 0);
      tick();
    end
    check("halt state", 32'(state), 32'd6);
    check("halted flag", 32'(halted), 32'd1);
    check("halt retired", 32'(retired), 32'd1);
    do_reset();
    check("reset from halt", 32'({state, halted}), 32'd0);
    check("reset retired", 32'(retired), 32'd0);

    // Counter wrap with a 4-bit counter, then reset during a MEM wait
    drive(1, OP_ADD, 0, 1, 1);
    tick();
    repeat (15 * 4) tick();
    check("retired before wrap", 32'(retired), 32'd15);
    repeat (4) tick();
    check("retired wrapped", 32'(retired), 32'd0);
    drive(1, OP_LB, 0, 1, 0);
    repeat (3) tick();                     // FETCH, DECODE, EXEC
    repeat (2) tick();                     // MEM stalls
    check("in mem wait", 32'(dmem_req), 32'd1);
    do_reset();
    check("reset in mem state", 32'(state), 32'd0);
    check("reset in mem dmem_req", 32'(dmem_req), 32'd0);

    // Randomized traffic against the model
    clear_trace();
    for (int i = 0; i < 3000; i++) begin
      if (burst > 0) burst--;
      else if ($urandom_range(0, 49) == 0) burst = $urandom_range(5, 10);
      reset        = (m_mode >= 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      run          = ($urandom_range(0, 3) != 0);
      opcode       = 4'($urandom);
      imm_flag     = 1'($urandom);
      branch_taken = 1'($urandom);
      imem_ready   = (burst == 0) && ($urandom_range(0, 3) != 0);
      dmem_ready   = (burst == 0) && ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule
